mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for memAck before aborting a transaction.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports reqA/reqB, input, 1 bit each: level request from port A (fetch) and port B (data).
REQ-005 SHALL have ports addrA/addrB, input, 32 bits each: byte address.
REQ-006 SHALL have ports weA/weB, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports dataInA/dataInB, input, 8 bits each: write data.
REQ-008 SHALL have ports outA/outB, output, 8 bits each: read data, held until the next completion on that port.
REQ-009 SHALL have ports busyA/busyB, output, 1 bit each: transaction accepted and not yet complete.
REQ-010 SHALL have port errA/errB, output, 1 bit each: the last transaction on that port timed out.
REQ-011 SHALL have ports memAddr (output, 32 bits), memWE (output, 1 bit), memDataOut (output, 8 bits), memReq (output, 1 bit): the single memory port.
REQ-012 SHALL have ports memDataIn (input, 8 bits) and memAck (input, 1 bit): memory read data and one-cycle completion strobe.

Function
REQ-013 SHALL be a pending request on port X when reqX=1, busyX=0, and armX=1; armX is set by reqX=0 and cleared on acceptance, so each reqX assertion yields exactly one transaction.
REQ-014 SHALL, on acceptance, latch addr/we/dataIn of the granted port and assert busyX on the next cycle.
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-016 SHALL transition IDLE->ISSUE when any request is pending.
REQ-017 SHALL, in ISSUE, drive memReq=1 with the latched fields for exactly one cycle, then go to WAIT.
REQ-018 SHALL, in WAIT, go to DONE on memAck=1 (capture memDataIn into outX if a read), or on timeout.
REQ-019 SHALL, in DONE, deassert busyX and return to IDLE; busyX therefore falls exactly one cycle after memAck.
REQ-020 SHALL arbitrate round-robin: on a simultaneous pending request, grant the port not granted last; after reset, A has priority.
REQ-021 SHALL accept a request arriving on the other port during a transaction and serve it after DONE, with no lost request.
REQ-022 SHALL keep a timeout counter cleared in ISSUE and incremented in WAIT; reaching TIMEOUT forces DONE with errX=1 and outX unchanged.
REQ-023 SHALL clear errX on the next successful completion of port X.
REQ-024 SHALL ignore memAck outside WAIT.
REQ-025 SHALL drive memDataOut and memWE only during ISSUE; both SHALL be 0 otherwise.
REQ-026 SHALL not modify outX on a write.
REQ-027 SHALL hold a worst-case latency of 3 + memory latency cycles from acceptance to busy fall, plus one full transaction if the other port was granted first.

Reset
REQ-028 SHALL, on reset, force state=IDLE, busyA/B=0, errA/B=0, outA/B=0, memReq=0, memWE=0, memAddr=0, memDataOut=0, last-grant=B, armA/B=1, counter=0.
REQ-029 SHALL, on reset mid-transaction, abandon the transaction immediately; a late memAck after reset is ignored per REQ-024.

Structure
REQ-030 SHALL place the state encoding (2-bit) and the grant IDs (PORT_A, PORT_B) in the shared package.
REQ-031 SHALL factor the round-robin grant logic into the sub-module rr_grant2 (inputs: two pending bits and last grant; output: grant).
REQ-032 SHALL keep all remaining logic inline, without further hierarchy.

Verification
REQ-033 SHALL verify a single read: reqA=1, addrA=0x10, memory acks 2 cycles after memReq with 0x5A -> busyA falls 1 cycle after ack, outA=0x5A, errA=0.
REQ-034 SHALL verify a simultaneous request: reqA=reqB=1 right after reset -> A served first, then B; on the next simultaneous pair B is served first.
REQ-035 SHALL verify a write: reqB=1, weB=1, addrB=360, dataInB=0x07 -> one memReq cycle with memWE=1, memAddr=360, memDataOut=0x07; outB unchanged.
REQ-036 SHALL verify timeout with TIMEOUT=4: memAck never asserted -> busyA falls after ~6 cycles, errA=1; the next successful read clears errA.
REQ-037 SHALL verify a held request: reqA held high across completion -> exactly one transaction until reqA drops and rises again.
REQ-038 SHALL verify reset in WAIT: assert reset, then apply a stale memAck -> all outputs at reset values, no busy pulse, outA=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port IDs and the
// memory command payload.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] data;
    } mem_cmd_t;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant: on a tie the port not granted last wins.
module rr_grant2
    import mem_arbiter_pkg::*;
(
    input  logic  pend_a_i,
    input  logic  pend_b_i,
    input  port_e last_i,
    output port_e grant_c_o
);

    always_comb begin
        grant_c_o = PORT_A;
        if (pend_a_i && pend_b_i) begin
            grant_c_o = other_port(last_i);
        end else if (pend_b_i) begin
            grant_c_o = PORT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port (A) and a data port (B) onto one memory port with
// one-shot level requests, round-robin grant and an ack timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqA,
    input  logic              reqB,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [ADDR_W-1:0] addrB,
    input  logic              weA,
    input  logic              weB,
    input  logic [DATA_W-1:0] dataInA,
    input  logic [DATA_W-1:0] dataInB,
    output logic [DATA_W-1:0] outA,
    output logic [DATA_W-1:0] outB,
    output logic              busyA,
    output logic              busyB,
    output logic              errA,
    output logic              errB,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memWE,
    output logic [DATA_W-1:0] memDataOut,
    output logic              memReq,
    input  logic [DATA_W-1:0] memDataIn,
    input  logic              memAck
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                   state_q, state_d;
    port_e                    cur_q, cur_d;
    port_e                    last_q, last_d;
    port_e                    grant;
    logic [1:0]               arm_q, arm_d;
    logic [1:0]               busy_q, busy_d;
    logic [1:0]               err_q, err_d;
    logic [1:0][DATA_W-1:0]   out_q, out_d;
    logic                     we_q, we_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    mem_cmd_t                 cmd_q, cmd_d;
    logic                     mem_req_q, mem_req_d;
    logic [1:0]               req;
    logic [1:0]               pend;
    mem_cmd_t                 grant_cmd;

    assign req  = {reqB, reqA};
    assign pend = req & ~busy_q & arm_q;

    rr_grant2 u_rr_grant2 (
        .pend_a_i  (pend[PORT_A]),
        .pend_b_i  (pend[PORT_B]),
        .last_i    (last_q),
        .grant_c_o (grant)
    );

    assign grant_cmd = (grant == PORT_A)
                     ? mem_cmd_t'{addr: addrA, we: weA, data: dataInA}
                     : mem_cmd_t'{addr: addrB, we: weB, data: dataInB};

    // Next-state and registered-output logic; the memory bus is zero outside ISSUE.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        busy_d    = busy_q;
        err_d     = err_q;
        out_d     = out_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        cmd_d     = '0;
        mem_req_d = 1'b0;
        arm_d     = arm_q | ~req;

        case (state_q)
            IDLE: begin
                if (|pend) begin
                    state_d       = ISSUE;
                    cur_d         = grant;
                    last_d        = grant;
                    arm_d[grant]  = 1'b0;
                    busy_d[grant] = 1'b1;
                    we_d          = grant_cmd.we;
                    cmd_d         = grant_cmd;
                    mem_req_d     = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // A late ack on the final wait cycle still counts as success.
                if (memAck) begin
                    state_d       = DONE;
                    busy_d[cur_q] = 1'b0;
                    err_d[cur_q]  = 1'b0;
                    if (!we_q) begin
                        out_d[cur_q] = memDataIn;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = DONE;
                    busy_d[cur_q] = 1'b0;
                    err_d[cur_q]  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_q     <= PORT_A;
            last_q    <= PORT_B;
            arm_q     <= 2'b11;
            busy_q    <= '0;
            err_q     <= '0;
            out_q     <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            cmd_q     <= '0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            arm_q     <= arm_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            out_q     <= out_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            mem_req_q <= mem_req_d;
        end
    end

    assign outA       = out_q[PORT_A];
    assign outB       = out_q[PORT_B];
    assign busyA      = busy_q[PORT_A];
    assign busyB      = busy_q[PORT_B];
    assign errA       = err_q[PORT_A];
    assign errB       = err_q[PORT_B];
    assign memAddr    = cmd_q.addr;
    assign memWE      = cmd_q.we;
    assign memDataOut = cmd_q.data;
    assign memReq     = mem_req_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// request pairs against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        reqA, reqB;
    logic [31:0] addrA, addrB;
    logic        weA, weB;
    logic [7:0]  dataInA, dataInB;
    logic [7:0]  outA, outB;
    logic        busyA, busyB, errA, errB;
    logic [31:0] memAddr;
    logic        memWE;
    logic [7:0]  memDataOut;
    logic        memReq;
    logic [7:0]  memDataIn;
    logic        memAck;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .reqA(reqA), .reqB(reqB), .addrA(addrA), .addrB(addrB),
        .weA(weA), .weB(weB), .dataInA(dataInA), .dataInB(dataInB),
        .outA(outA), .outB(outB), .busyA(busyA), .busyB(busyB),
        .errA(errA), .errB(errB),
        .memAddr(memAddr), .memWE(memWE), .memDataOut(memDataOut), .memReq(memReq),
        .memDataIn(memDataIn), .memAck(memAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  data;
        int          cyc;
        int          lat;
        logic [7:0]  rdata;
    } seen_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    // Memory responder and monitor state.
    bit         rsp_rand;
    int         rsp_lat;
    logic [7:0] rsp_data;
    bit         force_ack;
    logic [7:0] force_data;
    int         cd;
    logic [7:0] cd_data;
    bit         auto_drop;
    bit         prevA, prevB;
    int         riseA_cyc;
    int         idle_bus_err;
    int         busy_seen;
    seen_t      seen_q[$];
    int         fallA_q[$];
    int         fallB_q[$];

    // Reference model state.
    logic [31:0] t_addr[2];
    logic        t_we[2];
    logic [7:0]  t_data[2];
    logic [7:0]  m_out[2];
    logic        m_err[2];
    int          m_last;

    function automatic int first_port(input bit ra, input bit rb, input int dly, input int last);
        if (ra && rb) return (dly > 0) ? 0 : ((last == 0) ? 1 : 0);
        return ra ? 0 : 1;
    endfunction

    function automatic bit ack_ok(input int lat);
        return (lat >= 1) && (lat <= TO);
    endfunction

    task automatic tick();
        @(negedge clk);
        cycle++;
        memAck    = 1'b0;
        memDataIn = 8'($urandom);
        if (force_ack) begin
            memAck    = 1'b1;
            memDataIn = force_data;
            force_ack = 1'b0;
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                memAck    = 1'b1;
                memDataIn = cd_data;
            end
        end
        if (memReq === 1'b1) begin
            seen_t s;
            s.addr  = memAddr;
            s.we    = memWE;
            s.data  = memDataOut;
            s.cyc   = cycle;
            s.lat   = rsp_rand ? int'($urandom_range(1, TO + 2)) : rsp_lat;
            s.rdata = rsp_rand ? 8'($urandom) : rsp_data;
            cd      = s.lat;
            cd_data = s.rdata;
            seen_q.push_back(s);
        end else if (memWE !== 1'b0 || memDataOut !== 8'h00 || memAddr !== 32'h0) begin
            idle_bus_err++;
        end
        if (busyA === 1'b1 || busyB === 1'b1) busy_seen++;
        if (!prevA && busyA === 1'b1) riseA_cyc = cycle;
        if (prevA && busyA === 1'b0) begin
            fallA_q.push_back(cycle);
            if (auto_drop) reqA = 1'b0;
        end
        if (prevB && busyB === 1'b0) begin
            fallB_q.push_back(cycle);
            if (auto_drop) reqB = 1'b0;
        end
        prevA = (busyA === 1'b1);
        prevB = (busyB === 1'b1);
    endtask

    task automatic drive_fields();
        addrA = t_addr[0]; weA = t_we[0]; dataInA = t_data[0];
        addrB = t_addr[1]; weB = t_we[1]; dataInB = t_data[1];
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        reqA = 1'b0; reqB = 1'b0;
        addrA = '0; addrB = '0; weA = 1'b0; weB = 1'b0; dataInA = '0; dataInB = '0;
        cd = 0; force_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        m_out[0] = 8'h00; m_out[1] = 8'h00;
        m_err[0] = 1'b0;  m_err[1] = 1'b0;
        m_last = 1;
    endtask

    // Raises the selected requests (B optionally dly cycles after A) and waits
    // for every raised port to complete; each request drops when its busy falls.
    task automatic run_pair(input bit ra, input bit rb, input int dly, output bit hung);
        int n;
        seen_q.delete(); fallA_q.delete(); fallB_q.delete();
        hung = 1'b0;
        auto_drop = 1'b1;
        drive_fields();
        reqA = ra;
        if (dly == 0) reqB = rb;
        n = 0;
        while (!((!ra || fallA_q.size() > 0) && (!rb || fallB_q.size() > 0))) begin
            tick();
            n++;
            if (rb && n == dly) reqB = 1'b1;
            if (n > 80) begin
                hung = 1'b1;
                break;
            end
        end
        repeat (3) tick();
        reqA = 1'b0; reqB = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({busyA, busyB, errA, errB} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busyA, busyB, errA, errB});
        end
        n_tests++;
        if ({outA, outB} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_out: got %h expected 0000", {outA, outB});
        end
        n_tests++;
        if ({memReq, memWE, memAddr, memDataOut} !== 42'h0) begin
            n_fail++; $display("FAIL reset_mem: got %h expected 0", {memReq, memWE, memAddr, memDataOut});
        end
    endtask

    task automatic test_single_read();
        bit hung;
        int start;
        rsp_rand = 1'b0; rsp_lat = 2; rsp_data = 8'h5A;
        t_addr[0] = 32'h10; t_we[0] = 1'b0; t_data[0] = 8'h00;
        start = cycle;
        run_pair(1'b1, 1'b0, 0, hung);
        n_tests++;
        if (hung || seen_q.size() != 1 || fallA_q.size() != 1) begin
            n_fail++; $display("FAIL read_txn: hung=%0d memReq cycles=%0d expected 1", hung, seen_q.size());
        end else begin
            n_tests++;
            if (riseA_cyc != start + 1 || seen_q[0].cyc != start + 1) begin
                n_fail++; $display("FAIL read_accept: busy at %0d memReq at %0d expected %0d", riseA_cyc, seen_q[0].cyc, start + 1);
            end
            n_tests++;
            if (seen_q[0].addr !== 32'h10 || seen_q[0].we !== 1'b0) begin
                n_fail++; $display("FAIL read_cmd: got addr %h we %b expected 10 0", seen_q[0].addr, seen_q[0].we);
            end
            n_tests++;
            if (fallA_q[0] != seen_q[0].cyc + 2 + 1) begin
                n_fail++; $display("FAIL read_busy_fall: got %0d expected %0d", fallA_q[0], seen_q[0].cyc + 3);
            end
        end
        n_tests++;
        if (outA !== 8'h5A || errA !== 1'b0) begin
            n_fail++; $display("FAIL read_result: got out %h err %b expected 5a 0", outA, errA);
        end
        m_out[0] = 8'h5A; m_err[0] = 1'b0; m_last = 0;
    endtask

    task automatic test_simultaneous();
        bit hung;
        int fp;
        apply_reset();
        rsp_rand = 1'b0; rsp_lat = 1;
        t_addr[0] = 32'h100; t_we[0] = 1'b0; t_data[0] = 8'h11;
        t_addr[1] = 32'h200; t_we[1] = 1'b0; t_data[1] = 8'h22;
        for (int pass = 0; pass < 2; pass++) begin
            rsp_data = (pass == 0) ? 8'hC3 : 8'h3C;
            fp = first_port(1'b1, 1'b1, 0, m_last);
            run_pair(1'b1, 1'b1, 0, hung);
            n_tests++;
            if (hung || seen_q.size() != 2) begin
                n_fail++; $display("FAIL simul_count pass %0d: hung=%0d memReq cycles=%0d expected 2", pass, hung, seen_q.size());
            end else begin
                n_tests++;
                if (seen_q[0].addr !== t_addr[fp] || seen_q[1].addr !== t_addr[1 - fp]) begin
                    n_fail++; $display("FAIL simul_order pass %0d: got %h,%h expected %h,%h", pass,
                                       seen_q[0].addr, seen_q[1].addr, t_addr[fp], t_addr[1 - fp]);
                end
            end
            m_out[0] = rsp_data; m_out[1] = rsp_data; m_last = 1 - fp;
            n_tests++;
            if (outA !== m_out[0] || outB !== m_out[1]) begin
                n_fail++; $display("FAIL simul_out pass %0d: got %h,%h expected %h,%h", pass, outA, outB, m_out[0], m_out[1]);
            end
        end
    endtask

    task automatic test_write();
        bit hung;
        rsp_rand = 1'b0; rsp_lat = 2; rsp_data = 8'hF0;
        t_addr[1] = 32'd360; t_we[1] = 1'b1; t_data[1] = 8'h07;
        run_pair(1'b0, 1'b1, 0, hung);
        n_tests++;
        if (hung || seen_q.size() != 1) begin
            n_fail++; $display("FAIL write_count: hung=%0d memReq cycles=%0d expected 1", hung, seen_q.size());
        end else begin
            n_tests++;
            if (seen_q[0].addr !== 32'd360 || seen_q[0].we !== 1'b1 || seen_q[0].data !== 8'h07) begin
                n_fail++; $display("FAIL write_cmd: got addr %0d we %b data %h expected 360 1 07",
                                   seen_q[0].addr, seen_q[0].we, seen_q[0].data);
            end
        end
        n_tests++;
        if (outB !== m_out[1] || errB !== 1'b0) begin
            n_fail++; $display("FAIL write_outB: got %h err %b expected %h 0", outB, errB, m_out[1]);
        end
        m_last = 1;
    endtask

    task automatic test_timeout();
        bit hung;
        rsp_rand = 1'b0; rsp_lat = 0;
        t_addr[0] = 32'h40; t_we[0] = 1'b0;
        run_pair(1'b1, 1'b0, 0, hung);
        n_tests++;
        if (hung || seen_q.size() != 1 || fallA_q.size() != 1) begin
            n_fail++; $display("FAIL timeout_txn: hung=%0d memReq cycles=%0d expected 1", hung, seen_q.size());
        end else begin
            n_tests++;
            if (fallA_q[0] != seen_q[0].cyc + TO + 1) begin
                n_fail++; $display("FAIL timeout_fall: got %0d expected %0d", fallA_q[0], seen_q[0].cyc + TO + 1);
            end
        end
        n_tests++;
        if (errA !== 1'b1 || outA !== m_out[0]) begin
            n_fail++; $display("FAIL timeout_result: got err %b out %h expected 1 %h", errA, outA, m_out[0]);
        end
        rsp_lat = 3; rsp_data = 8'h99;
        run_pair(1'b1, 1'b0, 0, hung);
        n_tests++;
        if (hung || errA !== 1'b0 || outA !== 8'h99) begin
            n_fail++; $display("FAIL timeout_clear: got hung %0d err %b out %h expected 0 0 99", hung, errA, outA);
        end
        m_out[0] = 8'h99; m_err[0] = 1'b0; m_last = 0;
    endtask

    task automatic test_held();
        rsp_rand = 1'b0; rsp_lat = 1; rsp_data = 8'h66;
        t_addr[0] = 32'h80; t_we[0] = 1'b0;
        drive_fields();
        seen_q.delete();
        auto_drop = 1'b0;
        reqA = 1'b1;
        repeat (20) tick();
        n_tests++;
        if (seen_q.size() != 1 || busyA !== 1'b0) begin
            n_fail++; $display("FAIL held_once: got memReq cycles %0d busy %b expected 1 0", seen_q.size(), busyA);
        end
        reqA = 1'b0;
        tick();
        reqA = 1'b1;
        repeat (20) tick();
        n_tests++;
        if (seen_q.size() != 2) begin
            n_fail++; $display("FAIL held_rearm: got memReq cycles %0d expected 2", seen_q.size());
        end
        reqA = 1'b0;
        repeat (2) tick();
        auto_drop = 1'b1;
        m_out[0] = 8'h66; m_err[0] = 1'b0; m_last = 0;
    endtask

    task automatic test_random();
        bit hung;
        bit ra, rb;
        int dly, fp, p, fall, exp_fall;
        seen_t s;
        rsp_rand = 1'b1;
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(1, 3))
                1: begin ra = 1'b1; rb = 1'b0; end
                2: begin ra = 1'b0; rb = 1'b1; end
                default: begin ra = 1'b1; rb = 1'b1; end
            endcase
            dly = (ra && rb && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
            for (int k = 0; k < 2; k++) begin
                t_addr[k] = $urandom;
                t_we[k]   = 1'($urandom);
                t_data[k] = 8'($urandom);
            end
            fp = first_port(ra, rb, dly, m_last);
            run_pair(ra, rb, dly, hung);
            n_tests++;
            if (hung || seen_q.size() != int'(ra) + int'(rb)) begin
                n_fail++; $display("FAIL rand_count it %0d: hung=%0d memReq cycles=%0d expected %0d",
                                   it, hung, seen_q.size(), int'(ra) + int'(rb));
                continue;
            end
            for (int i = 0; i < seen_q.size(); i++) begin
                p = (i == 0) ? fp : 1 - fp;
                s = seen_q[i];
                n_tests++;
                if (s.addr !== t_addr[p] || s.we !== t_we[p] || (t_we[p] && s.data !== t_data[p])) begin
                    n_fail++; $display("FAIL rand_cmd it %0d slot %0d: got %h/%b/%h expected %h/%b/%h", it, i,
                                       s.addr, s.we, s.data, t_addr[p], t_we[p], t_data[p]);
                end
                exp_fall = s.cyc + (ack_ok(s.lat) ? s.lat + 1 : TO + 1);
                fall = (p == 0) ? ((fallA_q.size() > 0) ? fallA_q[0] : -1)
                                : ((fallB_q.size() > 0) ? fallB_q[0] : -1);
                n_tests++;
                if (fall != exp_fall) begin
                    n_fail++; $display("FAIL rand_fall it %0d port %0d: got %0d expected %0d", it, p, fall, exp_fall);
                end
                if (ack_ok(s.lat)) begin
                    m_err[p] = 1'b0;
                    if (!t_we[p]) m_out[p] = s.rdata;
                end else begin
                    m_err[p] = 1'b1;
                end
                m_last = p;
            end
            n_tests++;
            if (outA !== m_out[0] || outB !== m_out[1] || errA !== m_err[0] || errB !== m_err[1]) begin
                n_fail++; $display("FAIL rand_state it %0d: got %h %h %b %b expected %h %h %b %b", it,
                                   outA, outB, errA, errB, m_out[0], m_out[1], m_err[0], m_err[1]);
            end
        end
        rsp_rand = 1'b0;
        n_tests++;
        if (idle_bus_err !== 0) begin
            n_fail++; $display("FAIL idle_bus: got %0d non-zero bus cycles expected 0", idle_bus_err);
        end
    endtask

    task automatic test_reset_in_wait();
        int n;
        rsp_rand = 1'b0; rsp_lat = 0;
        t_addr[0] = 32'hA0; t_we[0] = 1'b0;
        drive_fields();
        seen_q.delete();
        reqA = 1'b1;
        n = 0;
        while (seen_q.size() == 0 && n < 10) begin
            tick();
            n++;
        end
        tick(); tick();
        n_tests++;
        if (busyA !== 1'b1) begin
            n_fail++; $display("FAIL rst_wait_busy: got %b expected 1", busyA);
        end
        reset = 1'b1;
        reqA  = 1'b0;
        #1;
        n_tests++;
        if (busyA !== 1'b0 || memReq !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: got busy %b memReq %b expected 0 0", busyA, memReq);
        end
        tick();
        reset = 1'b0;
        force_ack = 1'b1; force_data = 8'hEE;
        busy_seen = 0;
        seen_q.delete();
        repeat (6) tick();
        n_tests++;
        if (busy_seen != 0 || seen_q.size() != 0) begin
            n_fail++; $display("FAIL rst_stale_ack: got busy cycles %0d memReq cycles %0d expected 0 0", busy_seen, seen_q.size());
        end
        n_tests++;
        if ({outA, outB, errA, errB} !== 18'h0) begin
            n_fail++; $display("FAIL rst_outputs: got %h %h %b %b expected 00 00 0 0", outA, outB, errA, errB);
        end
        m_out[0] = 8'h00; m_out[1] = 8'h00; m_err[0] = 1'b0; m_err[1] = 1'b0; m_last = 1;
    endtask

    initial begin
        reset = 1'b1;
        memAck = 1'b0; memDataIn = 8'h00;
        rsp_rand = 1'b0; rsp_lat = 0; rsp_data = 8'h00;
        force_ack = 1'b0; force_data = 8'h00; cd = 0; cd_data = 8'h00;
        auto_drop = 1'b1; prevA = 1'b0; prevB = 1'b0; riseA_cyc = -1;
        idle_bus_err = 0; busy_seen = 0;
        for (int k = 0; k < 2; k++) begin
            t_addr[k] = '0; t_we[k] = 1'b0; t_data[k] = '0;
        end
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write();
        test_timeout();
        test_held();
        test_random();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
